// File: rtl/score_display_sequencer.sv
// Scoreboard sequencer: keeps both team scores, shares one external binary-to-BCD
// converter between them, and scans the four latched digits onto a common display bus.
module score_display_sequencer #(
  parameter int MAX_SCORE = 99,
  parameter int CONV_LAT  = 1,
  parameter int SCAN_DIV  = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_a_i,
  input  logic       inc_b_i,
  input  logic       clr_i,
  output logic [7:0] conv_bin_o,
  input  logic [3:0] conv_tens_i,
  input  logic [3:0] conv_ones_i,
  output logic [7:0] score_a_o,
  output logic [7:0] score_b_o,
  output logic [3:0] digit_o,
  output logic [3:0] digit_sel_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {IDLE, WAIT_A, CAP_A, WAIT_B, CAP_B} state_t;

  localparam logic [7:0]  SCORE_MAX = 8'(MAX_SCORE);
  localparam logic [2:0]  WAIT_LAST = 3'(CONV_LAT - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [7:0]  conv_bin_q, conv_bin_d;
  logic [7:0]  bcd_a_q, bcd_a_d;
  logic [7:0]  bcd_b_q, bcd_b_d;
  logic [7:0]  score_a_q, score_b_q;
  logic        dirty_q;
  logic        leave_idle;
  logic [15:0] scan_q;
  logic [3:0]  sel_q;

  // Clear wins; increments saturate at MAX_SCORE instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      score_a_q <= '0;
      score_b_q <= '0;
    end else begin
      if (inc_a_i && (score_a_q < SCORE_MAX)) score_a_q <= score_a_q + 8'd1;
      if (inc_b_i && (score_b_q < SCORE_MAX)) score_b_q <= score_b_q + 8'd1;
    end
  end

  assign leave_idle = (state_q == IDLE) && dirty_q;

  // A pulse on the same edge the FSM leaves IDLE keeps dirty set, so it is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i)                            dirty_q <= 1'b1;
    else if (clr_i || inc_a_i || inc_b_i) dirty_q <= 1'b1;
    else if (leave_idle)                  dirty_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      conv_bin_q <= '0;
      bcd_a_q    <= '0;
      bcd_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      conv_bin_q <= conv_bin_d;
      bcd_a_q    <= bcd_a_d;
      bcd_b_q    <= bcd_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    conv_bin_d = conv_bin_q;
    bcd_a_d    = bcd_a_q;
    bcd_b_d    = bcd_b_q;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          conv_bin_d = score_a_q;
          wait_d     = '0;
          state_d    = WAIT_A;
        end
      end
      WAIT_A: begin
        if (wait_q == WAIT_LAST) state_d = CAP_A;
        else                     wait_d  = wait_q + 3'd1;
      end
      CAP_A: begin
        bcd_a_d    = {conv_tens_i, conv_ones_i};
        conv_bin_d = score_b_q;
        wait_d     = '0;
        state_d    = WAIT_B;
      end
      WAIT_B: begin
        if (wait_q == WAIT_LAST) state_d = CAP_B;
        else                     wait_d  = wait_q + 3'd1;
      end
      CAP_B: begin
        bcd_b_d = {conv_tens_i, conv_ones_i};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan runs freely; the select rotates right each time the divider wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_q <= '0;
      sel_q  <= 4'b1000;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      sel_q  <= {sel_q[0], sel_q[3:1]};
    end else begin
      scan_q <= scan_q + 16'd1;
    end
  end

  always_comb begin
    case (sel_q)
      4'b1000: digit_o = bcd_a_q[7:4];
      4'b0100: digit_o = bcd_a_q[3:0];
      4'b0010: digit_o = bcd_b_q[7:4];
      4'b0001: digit_o = bcd_b_q[3:0];
      default: digit_o = 4'd0;
    endcase
  end

  assign conv_bin_o  = conv_bin_q;
  assign score_a_o   = score_a_q;
  assign score_b_o   = score_b_q;
  assign digit_sel_o = sel_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_score_display_sequencer.sv
// Randomised bench for score_display_sequencer with a behavioural converter and an
// arithmetic score/digit model.
module tb_score_display_sequencer;

  localparam int MAX_SCORE = 99;
  localparam int CONV_LAT  = 1;
  localparam int SCAN_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_a = 1'b0, inc_b = 1'b0, clr = 1'b0;
  logic [7:0] conv_bin;
  logic [3:0] conv_tens, conv_ones;
  logic [7:0] score_a, score_b;
  logic [3:0] digit, digit_sel;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int model_a  = 0;
  int model_b  = 0;

  score_display_sequencer #(
    .MAX_SCORE(MAX_SCORE), .CONV_LAT(CONV_LAT), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .inc_a_i(inc_a), .inc_b_i(inc_b), .clr_i(clr),
    .conv_bin_o(conv_bin), .conv_tens_i(conv_tens), .conv_ones_i(conv_ones),
    .score_a_o(score_a), .score_b_o(score_b), .digit_o(digit),
    .digit_sel_o(digit_sel), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural converter: operand delayed CONV_LAT edges, then split into decimal digits.
  logic [7:0] conv_pipe [CONV_LAT];
  always @(posedge clk) begin
    conv_pipe[0] <= conv_bin;
    for (int i = 1; i < CONV_LAT; i++) conv_pipe[i] <= conv_pipe[i-1];
  end
  assign conv_tens = 4'(conv_pipe[CONV_LAT-1] / 8'd10);
  assign conv_ones = 4'(conv_pipe[CONV_LAT-1] % 8'd10);

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic c);
    inc_a = a; inc_b = b; clr = c;
    @(posedge clk); #1;
    inc_a = 1'b0; inc_b = 1'b0; clr = 1'b0;
    if (c) begin
      model_a = 0;
      model_b = 0;
    end else begin
      if (a && model_a < MAX_SCORE) model_a++;
      if (b && model_b < MAX_SCORE) model_b++;
    end
    checkOutput("score_a", score_a, model_a);
    checkOutput("score_b", score_b, model_b);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_a = 0;
    model_b = 0;
    checkOutput("rst_score_a", score_a, 0);
    checkOutput("rst_score_b", score_b, 0);
    checkOutput("rst_conv_bin", conv_bin, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_digit_sel", digit_sel, 4'b1000);
    checkOutput("rst_digit", digit, 0);
  endtask

  // Worst case after the last pulse is one sequence finishing plus one more.
  task automatic waitIdle();
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_busy", busy, 0);
  endtask

  function automatic int expectedDigit(input logic [3:0] sel);
    case (sel)
      4'b1000: return model_a / 10;
      4'b0100: return model_a % 10;
      4'b0010: return model_b / 10;
      4'b0001: return model_b % 10;
      default: return 99;
    endcase
  endfunction

  task automatic checkScan();
    logic [3:0] cur;
    int n, hold;
    cur = digit_sel;
    n = 0;
    while (digit_sel == cur && n < SCAN_DIV + 2) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("scan_sync", int'(digit_sel == cur), 0);
    for (int k = 0; k < 4; k++) begin
      cur = digit_sel;
      hold = 0;
      while (digit_sel == cur && hold < SCAN_DIV + 2) begin
        checkOutput("digit", digit, expectedDigit(cur));
        hold++;
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
      checkOutput("hold", hold, SCAN_DIV);
      checkOutput("rotate", digit_sel, {cur[0], cur[3:1]});
    end
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int exp_busy [6] = '{1, 1, 1, 1, 0, 0};

    // Reset, then the single refresh sequence it triggers.
    @(posedge clk); #1;
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_busy", busy, exp_busy[i]);
    end
    checkScan();

    // 42 A pulses and 7 B pulses, spaced out.
    for (int i = 0; i < 42; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 9; j++) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 9; j++) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("score_a_42", score_a, 42);
    checkOutput("score_b_7", score_b, 7);
    checkScan();

    // Saturation with back-to-back pulses.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 105; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("score_a_sat", score_a, MAX_SCORE);
    waitIdle();
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      busy_cnt += int'(busy);
    end
    checkOutput("no_extra_seq", busy_cnt, 0);
    checkScan();

    // Clear beats simultaneous increments at 50/60.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) applyStimulus(i < 50, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr_prio_a", score_a, 0);
    checkOutput("clr_prio_b", score_b, 0);
    waitIdle();
    checkScan();

    // B pulse during WAIT_A: two sequences of 4 busy cycles each.
    applyStimulus(1'b1, 1'b0, 1'b0);
    busy_cnt = int'(busy);
    applyStimulus(1'b0, 1'b0, 1'b0);
    busy_cnt += int'(busy);
    applyStimulus(1'b0, 1'b1, 1'b0);
    busy_cnt += int'(busy);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      busy_cnt += int'(busy);
    end
    checkOutput("rerun_busy_cycles", busy_cnt, 8);
    checkScan();

    // Reset during WAIT_B with scores 33/44.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 44; i++) applyStimulus(i < 33, 1'b1, 1'b0);
    waitIdle();
    checkOutput("pre_rst_a", score_a, 33);
    checkOutput("pre_rst_b", score_b, 44);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("in_wait_b_busy", busy, 1);
    doReset();
    waitIdle();
    checkScan();

    // Randomised pulses against the arithmetic model.
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(39) == 0);
    waitIdle();
    checkScan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
